bayer_block_proc: RTL and testbench

- Parametrised successor to the camera path's raw-to-RGB and grayscale stages.
- Takes the raw Bayer stream from the capture block together with its X/Y counters, and demosaics each 2x2 Bayer block into one output pixel.
- A per-frame mode selects RGB, grayscale, binary threshold or inverted grayscale output.
- Sits between capture and the SDRAM write FIFOs and replaces the separate RGB/gray paths and their output mux.

---
 rtl/bayer_block_proc.sv | 141 ++++++++++++++
 tb/tb_bayer_block_proc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bayer_block_proc.sv
// ============================================================================
// Module   : bayer_block_proc
// Purpose  : Demosaics each 2x2 Bayer block into one RGB/gray/threshold pixel.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bayer_block_proc #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 1280,
  parameter int ADDR_W = 11
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [15:0]       iX_Cont,
  input  logic [15:0]       iY_Cont,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL,
  output logic [1:0]        oMODE
);

  localparam logic [1:0] c_MODE_RGB  = 2'd0;
  localparam logic [1:0] c_MODE_GRAY = 2'd1;
  localparam logic [1:0] c_MODE_THR  = 2'd2;
  localparam logic [1:0] c_MODE_INV  = 2'd3;

  logic [DATA_W-1:0] r_line [LINE_W];
  logic [ADDR_W-1:0] w_addr;
  logic              w_accept;
  logic              w_complete;
  logic              w_frame_start;
  logic [DATA_W-1:0] w_above;

  logic [DATA_W-1:0] r_pix;
  logic [DATA_W-1:0] r_above;
  logic [1:0]        r_mode;

  logic              r_s1_vld;
  logic [1:0]        r_s1_mode;
  logic [DATA_W-1:0] r_s1_red;
  logic [DATA_W-1:0] r_s1_blue;
  logic [DATA_W:0]   r_s1_gsum;

  logic [DATA_W-1:0] w_g;
  logic [DATA_W+1:0] w_ysum;
  logic [DATA_W-1:0] w_y;

  assign w_accept      = iDVAL && (iX_Cont < 16'(LINE_W));
  assign w_addr        = iX_Cont[ADDR_W-1:0];
  assign w_complete    = w_accept && iX_Cont[0] && iY_Cont[0];
  assign w_frame_start = w_accept && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign w_above       = r_line[w_addr];

  // Read-before-write: w_above is sampled combinationally, the write lands at the edge.
  always_ff @(posedge iCLK) begin
    if (w_accept) r_line[w_addr] <= iDATA;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pix     <= '0;
      r_above   <= '0;
      r_mode    <= c_MODE_RGB;
      r_s1_vld  <= 1'b0;
      r_s1_mode <= c_MODE_RGB;
      r_s1_red  <= '0;
      r_s1_blue <= '0;
      r_s1_gsum <= '0;
    end else begin
      r_s1_vld <= w_complete;
      if (w_accept) begin
        r_pix   <= iDATA;
        r_above <= w_above;
      end
      if (w_frame_start) r_mode <= iMODE;
      // r_above still holds buffer[x-1] and r_pix holds the pixel left of iDATA.
      if (w_complete) begin
        r_s1_mode <= r_mode;
        r_s1_red  <= w_above;
        r_s1_blue <= r_pix;
        r_s1_gsum <= {1'b0, r_above} + {1'b0, iDATA};
      end
    end
  end

  assign w_g    = r_s1_gsum[DATA_W:1];
  assign w_ysum = {2'b00, r_s1_red} + {2'b00, r_s1_blue}
                + ({1'b0, r_s1_gsum} & {{(DATA_W+1){1'b1}}, 1'b0});
  assign w_y    = DATA_W'(w_ysum >> 2);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oDVAL  <= 1'b0;
    end else begin
      oDVAL <= r_s1_vld;
      if (r_s1_vld) begin
        case (r_s1_mode)
          c_MODE_RGB: begin
            oRed   <= r_s1_red;
            oGreen <= w_g;
            oBlue  <= r_s1_blue;
          end
          c_MODE_GRAY: begin
            oRed   <= w_y;
            oGreen <= w_y;
            oBlue  <= w_y;
          end
          c_MODE_THR: begin
            oRed   <= (w_y >= iTHRESH) ? '1 : '0;
            oGreen <= (w_y >= iTHRESH) ? '1 : '0;
            oBlue  <= (w_y >= iTHRESH) ? '1 : '0;
          end
          c_MODE_INV: begin
            oRed   <= ~w_y;
            oGreen <= ~w_y;
            oBlue  <= ~w_y;
          end
          default: begin
            oRed   <= r_s1_red;
            oGreen <= w_g;
            oBlue  <= r_s1_blue;
          end
        endcase
      end
    end
  end

  assign oMODE = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_bayer_block_proc.sv
// ============================================================================
// Module   : tb_bayer_block_proc
// Purpose  : Directed self-checking bench for bayer_block_proc (LINE_W=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bayer_block_proc;

  logic        clk;
  logic        rst;
  logic [11:0] i_data;
  logic        i_dval;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic [1:0]  i_mode;
  logic [11:0] i_thresh;
  logic [11:0] o_red, o_green, o_blue;
  logic        o_dval;
  logic [1:0]  o_mode;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int bad_ones = 0;
  int base;

  bayer_block_proc #(.DATA_W(12), .LINE_W(8), .ADDR_W(3)) u_dut (
    .iCLK(clk), .iRST(rst), .iDATA(i_data), .iDVAL(i_dval),
    .iX_Cont(i_x), .iY_Cont(i_y), .iMODE(i_mode), .iTHRESH(i_thresh),
    .oRed(o_red), .oGreen(o_green), .oBlue(o_blue),
    .oDVAL(o_dval), .oMODE(o_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_dval) begin
      pulses = pulses + 1;
      if (o_red != 12'hFFF || o_green != 12'hFFF || o_blue != 12'hFFF)
        bad_ones = bad_ones + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic px(input int x, input int y, input int d);
    @(negedge clk);
    i_dval = 1'b1;
    i_x    = 16'(x);
    i_y    = 16'(y);
    i_data = 12'(d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_dval = 1'b0;
    end
  endtask

  // Standard 2x2 block: row0 = 100,200 ; row1 = 300,101
  task automatic block(input int gap);
    px(0, 0, 100);
    px(1, 0, 200);
    px(0, 1, 300);
    if (gap > 0) idle(gap);
    px(1, 1, 101);
    idle(4);
  endtask

  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    check({tag, "_r"}, o_red, r);
    check({tag, "_g"}, o_green, g);
    check({tag, "_b"}, o_blue, b);
  endtask

  initial begin
    rst = 1'b1; i_data = '0; i_dval = 1'b0; i_x = '0; i_y = '0;
    i_mode = 2'd0; i_thresh = '0;
    repeat (3) @(negedge clk);
    check("rst_dval", o_dval, 0);
    chk_rgb("rst", 0, 0, 0);
    check("rst_mode", o_mode, 0);
    rst = 1'b0;
    idle(2);

    // Mode 0 with exact latency check
    base = pulses;
    i_mode = 2'd0;
    px(0, 0, 100); px(1, 0, 200); px(0, 1, 300);
    check("no_early_pulse", pulses - base, 0);
    px(1, 1, 101);
    @(negedge clk); i_dval = 1'b0;
    check("lat_1clk_dval", o_dval, 0);
    @(negedge clk);
    check("lat_2clk_dval", o_dval, 1);
    chk_rgb("rgb", 200, 100, 300);
    @(negedge clk);
    check("pulse_width", o_dval, 0);
    idle(2);
    check("rgb_pulses", pulses - base, 1);
    chk_rgb("rgb_hold", 200, 100, 300);

    i_mode = 2'd1; block(0);
    chk_rgb("gray", 175, 175, 175);
    check("gray_mode", o_mode, 1);

    i_mode = 2'd3; block(0);
    chk_rgb("inv", 3920, 3920, 3920);

    i_mode = 2'd2; i_thresh = 12'd175; block(0);
    chk_rgb("thr175", 4095, 4095, 4095);
    i_thresh = 12'd176; block(0);
    chk_rgb("thr176", 0, 0, 0);

    // Mid-frame mode change has no effect until next frame
    i_mode = 2'd0;
    px(0, 0, 100); px(1, 0, 200);
    i_mode = 2'd1;
    px(0, 1, 300); px(1, 1, 101); idle(4);
    chk_rgb("midchg", 200, 100, 300);
    check("midchg_mode", o_mode, 0);
    block(0);
    chk_rgb("nextframe", 175, 175, 175);
    check("nextframe_mode", o_mode, 1);

    // Full 8x4 frame of 4095 with out-of-line pixels carrying 0
    i_mode = 2'd0;
    base = pulses; bad_ones = 0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) px(x, y, 4095);
      px(8, y, 0);
      px(9, y, 0);
    end
    idle(4);
    check("full_pulses", pulses - base, 8);
    check("full_bad", bad_ones, 0);

    // iDVAL gap inside the completing row
    block(0);
    block(3);
    chk_rgb("gap", 200, 100, 300);

    // Reset while a block sits in stage 1
    i_mode = 2'd1;
    block(0);
    check("pre_rst_mode", o_mode, 1);
    base = pulses;
    px(0, 0, 100); px(1, 0, 200); px(0, 1, 300); px(1, 1, 101);
    @(posedge clk);
    #1;
    i_dval = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_dval", o_dval, 0);
    chk_rgb("rst_mid", 0, 0, 0);
    check("rst_mid_mode", o_mode, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("rst_no_pulse", pulses - base, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
